// File: rtl/regs_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// registered commit stage and a pending-write scoreboard for RAW stalls.
module regs_wb_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*5-1:0]  req_addr,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            alloc_valid,
  input  logic [4:0]      alloc_addr,
  output logic            RegWrite,
  output logic [4:0]      Wt_addr,
  output logic [DW-1:0]   Wt_data,
  output logic [31:0]     busy
);

  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = 5;

  logic [AW-1:0] addr_arr [N];
  logic [DW-1:0] data_arr [N];

  logic [LW-1:0] last;
  logic [LW-1:0] grant_idx;
  logic          grant_any;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          commit;
  logic [31:0]   busy_next;
  int unsigned   idx;

  for (genvar i = 0; i < int'(N); i++) begin : g_unpack
    assign addr_arr[i] = req_addr[AW*i +: AW];
    assign data_arr[i] = req_data[DW*i +: DW];
  end

  // Search last+1, last+2, ... modulo N; first valid requester wins.
  always_comb begin
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = last;
    req_ready = '0;
    if (rst) begin
      for (int unsigned k = 1; k <= N; k++) begin
        idx = (32'(last) + k) % N;
        if (!grant_any && req_valid[LW'(idx)]) begin
          grant_any = 1'b1;
          grant_idx = LW'(idx);
        end
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign sel_addr = addr_arr[grant_idx];
  assign sel_data = data_arr[grant_idx];
  assign commit   = grant_any && (sel_addr != '0);

  // Clear on commit first so a same-edge allocation of that register wins.
  always_comb begin
    busy_next = busy;
    if (RegWrite) busy_next[Wt_addr] = 1'b0;
    if (alloc_valid && (alloc_addr != '0)) busy_next[alloc_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last     <= LW'(N - 1);
      RegWrite <= 1'b0;
      Wt_addr  <= '0;
      Wt_data  <= '0;
      busy     <= '0;
    end else begin
      if (grant_any) last <= grant_idx;
      RegWrite <= commit;
      if (commit) begin
        Wt_addr <= sel_addr;
        Wt_data <= sel_data;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed self-checking bench for regs_wb_arbiter (N=3, DW=32).
module tb_regs_wb_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*5-1:0]  req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            alloc_valid;
  logic [4:0]      alloc_addr;
  logic            RegWrite;
  logic [4:0]      Wt_addr;
  logic [DW-1:0]   Wt_data;
  logic [31:0]     busy;

  logic [4:0]    a [N];
  logic [DW-1:0] d [N];

  int checks   = 0;
  int failures = 0;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  always #5 clk = ~clk;

  regs_wb_arbiter #(.N(N), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .alloc_valid(alloc_valid),
    .alloc_addr (alloc_addr),
    .RegWrite   (RegWrite),
    .Wt_addr    (Wt_addr),
    .Wt_data    (Wt_data),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int order [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst = 1'b0;
    req_valid = 3'b111;
    alloc_valid = 1'b0;
    alloc_addr = '0;
    for (int i = 0; i < int'(N); i++) begin
      a[i] = 5'(i + 1);
      d[i] = 32'hA0 + 32'(i);
    end

    // Reset held two cycles with all requesters valid
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_regwrite", 64'(RegWrite), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_wt_addr", 64'(Wt_addr), 64'(0));
      chk("rst_wt_data", 64'(Wt_data), 64'(0));
    end

    // Release; full contention gives 0,1,2,0,1,2
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("fair_ready", 64'(req_ready), 64'(3'b001 << order[c]));
      tick();
      chk("fair_regwrite", 64'(RegWrite), 64'(1));
      chk("fair_wt_addr", 64'(Wt_addr), 64'(order[c] + 1));
      chk("fair_wt_data", 64'(Wt_data), 64'(32'hA0 + 32'(order[c])));
    end
    req_valid = 3'b000;
    #1;
    chk("idle_ready", 64'(req_ready), 64'(0));
    tick();
    chk("idle_regwrite", 64'(RegWrite), 64'(0));
    chk("idle_hold_addr", 64'(Wt_addr), 64'(3));
    chk("idle_hold_data", 64'(Wt_data), 64'(32'hA2));

    // Single write from requester 1
    req_valid = 3'b010;
    a[1] = 5'd5;
    d[1] = 32'hDEADBEEF;
    #1;
    chk("single_ready", 64'(req_ready), 64'(3'b010));
    tick();
    req_valid = 3'b000;
    chk("single_regwrite", 64'(RegWrite), 64'(1));
    chk("single_wt_addr", 64'(Wt_addr), 64'(5));
    chk("single_wt_data", 64'(Wt_data), 64'(32'hDEADBEEF));
    tick();
    chk("single_pulse", 64'(RegWrite), 64'(0));

    // x0 write is accepted and dropped; x0 allocation ignored
    req_valid = 3'b001;
    a[0] = 5'd0;
    d[0] = 32'h1234;
    #1;
    chk("x0_ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = 3'b000;
    chk("x0_regwrite", 64'(RegWrite), 64'(0));
    chk("x0_hold_addr", 64'(Wt_addr), 64'(5));
    chk("x0_hold_data", 64'(Wt_data), 64'(32'hDEADBEEF));
    alloc_valid = 1'b1;
    alloc_addr = 5'd0;
    tick();
    alloc_valid = 1'b0;
    chk("x0_busy", 64'(busy), 64'(0));

    // Scoreboard: alloc x7, requester 2 commits it
    alloc_valid = 1'b1;
    alloc_addr = 5'd7;
    tick();
    alloc_valid = 1'b0;
    chk("sb_set", 64'(busy), 64'(32'h80));
    tick();
    chk("sb_hold", 64'(busy), 64'(32'h80));
    req_valid = 3'b100;
    a[2] = 5'd7;
    d[2] = 32'h77;
    #1;
    chk("sb_ready", 64'(req_ready), 64'(3'b100));
    tick();
    req_valid = 3'b000;
    chk("sb_commit", 64'(RegWrite), 64'(1));
    chk("sb_commit_addr", 64'(Wt_addr), 64'(7));
    chk("sb_busy_t1", 64'(busy), 64'(32'h80));
    tick();
    chk("sb_cleared", 64'(busy), 64'(0));
    chk("sb_regwrite_off", 64'(RegWrite), 64'(0));

    // Allocation on the commit edge wins over the clear
    alloc_valid = 1'b1;
    alloc_addr = 5'd7;
    tick();
    alloc_valid = 1'b0;
    chk("sb_realloc", 64'(busy), 64'(32'h80));
    req_valid = 3'b100;
    #1;
    chk("sb2_ready", 64'(req_ready), 64'(3'b100));
    tick();
    req_valid = 3'b000;
    chk("sb2_commit", 64'(RegWrite), 64'(1));
    alloc_valid = 1'b1;
    alloc_addr = 5'd7;
    tick();
    alloc_valid = 1'b0;
    chk("sb_collide_busy", 64'(busy), 64'(32'h80));

    // Mid-operation reset: pending grant is lost, state cleared
    req_valid = 3'b001;
    a[0] = 5'd9;
    d[0] = 32'h99;
    #1;
    chk("mr_ready_pre", 64'(req_ready), 64'(3'b001));
    rst = 1'b0;
    #1;
    chk("mr_ready_rst", 64'(req_ready), 64'(0));
    tick();
    chk("mr_regwrite", 64'(RegWrite), 64'(0));
    chk("mr_wt_addr", 64'(Wt_addr), 64'(0));
    chk("mr_wt_data", 64'(Wt_data), 64'(0));
    chk("mr_busy", 64'(busy), 64'(0));
    rst = 1'b1;
    #1;
    chk("mr_ready_post", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = 3'b000;
    chk("mr_regwrite_post", 64'(RegWrite), 64'(1));
    chk("mr_wt_addr_post", 64'(Wt_addr), 64'(9));
    chk("mr_wt_data_post", 64'(Wt_data), 64'(32'h99));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
